// File: rtl/regfile_alu_pipe.sv
// Two-stage register file + ALU execute datapath with same-cycle operand bypass.
// Define ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int SW    = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Hold,
    input  logic [3:0]       Op,
    input  logic [AW-1:0]    RS1,
    input  logic [AW-1:0]    RS2,
    input  logic [AW-1:0]    RD,
    input  logic             WbEn,
    input  logic [SW-1:0]    ShAmt,
    output logic             OutValid,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Ovf,
    output logic             OvfSticky,
    input  logic             ClrOvf,
    output logic             Illegal,
    input  logic [AW-1:0]    DbgAddr,
    output logic [WIDTH-1:0] DbgData
);
    localparam int NREG = 2 ** AW;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SGT = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;

    logic [WIDTH-1:0] regs [NREG];

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [AW-1:0]    s1_rd;
    logic             s1_wb;
    logic [SW-1:0]    s1_sh;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] arr1;
    logic [WIDTH-1:0] arr2;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             rd_ok;
    logic             byp_ok;
    logic             wr_en;

    assign InReady = ~Hold;

`ifdef ZERO_REG_EN
    assign arr1    = (RS1 == '0) ? '0 : regs[RS1];
    assign arr2    = (RS2 == '0) ? '0 : regs[RS2];
    assign DbgData = (DbgAddr == '0) ? '0 : regs[DbgAddr];
    assign rd_ok   = (s1_rd != '0);
`else
    assign arr1    = regs[RS1];
    assign arr2    = regs[RS2];
    assign DbgData = regs[DbgAddr];
    assign rd_ok   = 1'b1;
`endif

    // "Writing" means the s1 op will actually commit to the array.
    assign byp_ok = s1_valid & s1_wb & ~alu_ill & rd_ok;
    assign opa    = (byp_ok && RS1 == s1_rd) ? alu_res : arr1;
    assign opb    = (byp_ok && RS2 == s1_rd) ? alu_res : arr2;
    assign wr_en  = byp_ok & ~Hold;

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &
                          (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &
                          (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND: alu_res = s1_a & s1_b;
            OP_OR:  alu_res = s1_a | s1_b;
            OP_SLL: alu_res = s1_a << s1_sh;
            OP_SRL: alu_res = s1_a >> s1_sh;
            OP_SRA: alu_res = $unsigned($signed(s1_a) >>> s1_sh);
            OP_SGT: alu_res[0] = ($signed(s1_a) > $signed(s1_b));
            OP_SLT: alu_res[0] = ($signed(s1_a) < $signed(s1_b));
            OP_XOR: alu_res = s1_a ^ s1_b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_rd     <= '0;
            s1_wb     <= 1'b0;
            s1_sh     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            OutValid  <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Ovf       <= 1'b0;
            Illegal   <= 1'b0;
            OvfSticky <= 1'b0;
        end else begin
            if (!Hold) begin
                s1_valid <= InValid;
                if (InValid) begin
                    s1_op <= Op;
                    s1_rd <= RD;
                    s1_wb <= WbEn;
                    s1_sh <= ShAmt;
                    s1_a  <= opa;
                    s1_b  <= opb;
                end
                OutValid <= s1_valid;
                if (s1_valid) begin
                    Result  <= alu_res;
                    Zero    <= (alu_res == '0);
                    Ovf     <= alu_ovf;
                    Illegal <= alu_ill;
                end
                if (wr_en) regs[s1_rd] <= alu_res;
            end else begin
                OutValid <= 1'b0;
            end
            if (ClrOvf) OvfSticky <= 1'b0;
            else if (!Hold && s1_valid && alu_ovf) OvfSticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe; registers are seeded by forcing the stage-1 operand.
// Honours ZERO_REG_EN for the register-0 check.
module tb_regfile_alu_pipe;
    logic        Clk = 1'b0;
    logic        Rst, InValid, InReady, Hold, WbEn;
    logic [3:0]  Op;
    logic [4:0]  RS1, RS2, RD, ShAmt, DbgAddr;
    logic        OutValid, Zero, Ovf, OvfSticky, ClrOvf, Illegal;
    logic [31:0] Result, DbgData;

    int tests = 0;
    int fails = 0;

    regfile_alu_pipe dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .Hold(Hold), .Op(Op), .RS1(RS1), .RS2(RS2), .RD(RD), .WbEn(WbEn),
        .ShAmt(ShAmt), .OutValid(OutValid), .Result(Result), .Zero(Zero),
        .Ovf(Ovf), .OvfSticky(OvfSticky), .ClrOvf(ClrOvf),
        .Illegal(Illegal), .DbgAddr(DbgAddr), .DbgData(DbgData)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wb, input logic [4:0] sh);
        InValid = 1'b1;
        Op = op; RS1 = rs1; RS2 = rs2; RD = rd; WbEn = wb; ShAmt = sh;
        tick();
    endtask

    task automatic load(input logic [4:0] rd, input logic [31:0] val);
        issue(4'd0, 5'd0, 5'd0, rd, 1'b1, 5'd0);
        InValid = 1'b0;
        force dut.s1_a = val;
        force dut.s1_b = 32'd0;
        tick();
        release dut.s1_a;
        release dut.s1_b;
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] sh, input logic [31:0] exp);
        issue(op, rs1, rs2, 5'd0, 1'b0, sh);
        InValid = 1'b0;
        tick();
        chk({tag, "_valid"}, {31'd0, OutValid}, 32'd1);
        chk(tag, Result, exp);
    endtask

    initial begin
        Rst = 1'b1; InValid = 1'b0; Hold = 1'b0; WbEn = 1'b0; ClrOvf = 1'b0;
        Op = '0; RS1 = '0; RS2 = '0; RD = '0; ShAmt = '0; DbgAddr = '0;
        tick(); tick();
        Rst = 1'b0;
        tick();
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd0);
        chk("rst_sticky", {31'd0, OvfSticky}, 32'd0);
        chk("rst_inready", {31'd0, InReady}, 32'd1);

        // 1: latency and zero flag
        issue(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 5'd0);
        InValid = 1'b0;
        chk("t1_early", {31'd0, OutValid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, OutValid}, 32'd1);
        chk("t1_result", Result, 32'd0);
        chk("t1_zero", {31'd0, Zero}, 32'd1);
        DbgAddr = 5'd1;
        #1 chk("t1_dbg", DbgData, 32'd0);

        // 2: back-to-back with bypass
        load(5'd1, 32'hFFFF_FFFE);
        load(5'd2, 32'd1200);
        issue(4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 5'd0);
        issue(4'd1, 5'd3, 5'd2, 5'd4, 1'b1, 5'd0);
        InValid = 1'b0;
        chk("t2_add", Result, 32'd1198);
        chk("t2_add_valid", {31'd0, OutValid}, 32'd1);
        tick();
        chk("t2_sub", Result, 32'hFFFF_FFFE);
        chk("t2_sub_valid", {31'd0, OutValid}, 32'd1);
        DbgAddr = 5'd4;
        #1 chk("t2_dbg_r4", DbgData, 32'hFFFF_FFFE);
        DbgAddr = 5'd3;
        #1 chk("t2_dbg_r3", DbgData, 32'd1198);

        // 3: overflow and sticky clear priority
        load(5'd5, 32'h7FFF_FFFF);
        load(5'd6, 32'd1);
        issue(4'd0, 5'd5, 5'd6, 5'd7, 1'b1, 5'd0);
        InValid = 1'b0;
        tick();
        chk("t3_add", Result, 32'h8000_0000);
        chk("t3_ovf", {31'd0, Ovf}, 32'd1);
        chk("t3_sticky", {31'd0, OvfSticky}, 32'd1);
        issue(4'd0, 5'd5, 5'd6, 5'd8, 1'b0, 5'd0);
        InValid = 1'b0;
        ClrOvf = 1'b1;
        tick();
        ClrOvf = 1'b0;
        chk("t3_clr_ovf", {31'd0, Ovf}, 32'd1);
        chk("t3_clr_sticky", {31'd0, OvfSticky}, 32'd0);
        run("t3_sub", 4'd1, 5'd7, 5'd6, 5'd0, 32'h7FFF_FFFF);
        chk("t3_sub_ovf", {31'd0, Ovf}, 32'd1);
        chk("t3_sub_sticky", {31'd0, OvfSticky}, 32'd1);
        run("t3_noovf", 4'd0, 5'd1, 5'd2, 5'd0, 32'd1198);
        chk("t3_noovf_flag", {31'd0, Ovf}, 32'd0);

        // 4: shifts, compares, logic ops
        load(5'd10, 32'd1300);
        run("t4_sra", 4'd6, 5'd7, 5'd0, 5'd31, 32'hFFFF_FFFF);
        run("t4_sll", 4'd4, 5'd1, 5'd0, 5'd2, 32'hFFFF_FFF8);
        run("t4_srl", 4'd5, 5'd1, 5'd0, 5'd4, 32'h0FFF_FFFF);
        run("t4_and", 4'd2, 5'd1, 5'd2, 5'd0, 32'h0000_04B0);
        run("t4_or", 4'd3, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFE);
        run("t4_xor", 4'd9, 5'd1, 5'd2, 5'd0, 32'hFFFF_FB4E);
        run("t4_sgt", 4'd7, 5'd1, 5'd10, 5'd0, 32'd0);
        run("t4_slt", 4'd8, 5'd1, 5'd10, 5'd0, 32'd1);

        // 5: hold freezes the in-flight op
        issue(4'd0, 5'd1, 5'd2, 5'd11, 1'b1, 5'd0);
        InValid = 1'b0;
        Hold = 1'b1;
        DbgAddr = 5'd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_valid", {31'd0, OutValid}, 32'd0);
            chk("t5_hold_ready", {31'd0, InReady}, 32'd0);
            chk("t5_hold_result", Result, 32'd1);
            chk("t5_hold_dbg", DbgData, 32'd0);
        end
        Hold = 1'b0;
        tick();
        chk("t5_done_valid", {31'd0, OutValid}, 32'd1);
        chk("t5_done_result", Result, 32'd1198);
        chk("t5_done_dbg", DbgData, 32'd1198);
        tick();
        chk("t5_single_pulse", {31'd0, OutValid}, 32'd0);

        // 6: illegal op, reset mid-flight, register 0
        issue(4'hF, 5'd1, 5'd2, 5'd2, 1'b1, 5'd0);
        InValid = 1'b0;
        tick();
        chk("t6_ill_valid", {31'd0, OutValid}, 32'd1);
        chk("t6_ill_flag", {31'd0, Illegal}, 32'd1);
        chk("t6_ill_result", Result, 32'd0);
        chk("t6_ill_zero", {31'd0, Zero}, 32'd1);
        chk("t6_ill_ovf", {31'd0, Ovf}, 32'd0);
        DbgAddr = 5'd2;
        #1 chk("t6_ill_rd", DbgData, 32'd1200);

        issue(4'd0, 5'd1, 5'd2, 5'd13, 1'b1, 5'd0);
        InValid = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("t6_rst_valid", {31'd0, OutValid}, 32'd0);
        chk("t6_rst_result", Result, 32'd0);
        tick();
        chk("t6_rst_valid2", {31'd0, OutValid}, 32'd0);
        DbgAddr = 5'd13;
        #1 chk("t6_rst_nowrite", DbgData, 32'd0);

        load(5'd0, 32'd5);
        DbgAddr = 5'd0;
`ifdef ZERO_REG_EN
        #1 chk("t6_r0", DbgData, 32'd0);
`else
        #1 chk("t6_r0", DbgData, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
